// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C byte master between NREQ requesters
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   req/req_addr/req_op/req_din  per-requester request level and transaction fields
//   gnt                          one-hot owner of the master
//   rsp_valid/rsp_data/rsp_err/rsp_tout  one-cycle response to the granted requester
//   m_newd/m_addr/m_op/m_din     command handshake towards the master
//   m_dout/m_busy/m_ack_err/m_done  status from the master
module i2c_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 50000,
    parameter int TW      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_op,
    input  logic [8*NREQ-1:0] req_din,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    output logic              rsp_tout,
    output logic              m_newd,
    output logic [6:0]        m_addr,
    output logic              m_op,
    output logic [7:0]        m_din,
    input  logic [7:0]        m_dout,
    input  logic              m_busy,
    input  logic              m_ack_err,
    input  logic              m_done
);
    localparam int LW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [LW-1:0] last;
    logic [LW-1:0] win;
    logic [LW-1:0] idx;
    logic [6:0]    sel_addr;
    logic          sel_op;
    logic [7:0]    sel_din;
    logic [TW-1:0] wd;
    logic          err_seen;

    // Scan downwards so the requester closest after last wins.
    always_comb begin
        win = last;
        idx = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = LW'((int'(last) + k) % NREQ);
            if (req[idx]) win = idx;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_op   = 1'b0;
        sel_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == LW'(i)) begin
                sel_addr = req_addr[7*i +: 7];
                sel_op   = req_op[i];
                sel_din  = req_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LW'(NREQ - 1);
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_tout  <= 1'b0;
            m_newd    <= 1'b0;
            m_addr    <= '0;
            m_op      <= 1'b0;
            m_din     <= '0;
            wd        <= '0;
            err_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req && !m_busy) begin
                        gnt    <= NREQ'(1) << win;
                        m_addr <= sel_addr;
                        m_op   <= sel_op;
                        m_din  <= sel_din;
                        last   <= win;
                        m_newd <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_newd   <= 1'b0;
                    wd       <= '0;
                    err_seen <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wd <= (&wd) ? wd : wd + 1'b1;
                    if (m_ack_err) err_seen <= 1'b1;
                    // done takes priority over a timeout landing in the same cycle
                    if (m_done) begin
                        rsp_data  <= m_op ? m_dout : 8'h00;
                        rsp_err   <= err_seen | m_ack_err;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wd >= TW'(TIMEOUT - 1)) begin
                        rsp_data  <= 8'h00;
                        rsp_err   <= 1'b1;
                        rsp_tout  <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    gnt       <= '0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_tout  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: randomized checks of the arbiter against a round-robin reference model
module tb_i2c_req_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 100;
    localparam int TW      = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_op;
    logic [8*NREQ-1:0] req_din;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic              rsp_tout;
    logic              m_newd;
    logic [6:0]        m_addr;
    logic              m_op;
    logic [7:0]        m_din;
    logic [7:0]        m_dout;
    logic              m_busy;
    logic              m_ack_err;
    logic              m_done;

    logic [6:0] addr_a [NREQ];
    logic       op_a   [NREQ];
    logic [7:0] din_a  [NREQ];
    int rr_last;
    int checks;
    int passed;

    int              o_newd_lat, o_resp_cyc, o_extra_newd, o_unstable;
    bit              o_ok;
    logic [NREQ-1:0] o_gnt;
    logic [7:0]      o_data, o_din;
    logic            o_err, o_tout, o_op;
    logic [6:0]      o_addr;

    i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_op(req_op),
        .req_din(req_din), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_tout(rsp_tout), .m_newd(m_newd), .m_addr(m_addr),
        .m_op(m_op), .m_din(m_din), .m_dout(m_dout), .m_busy(m_busy),
        .m_ack_err(m_ack_err), .m_done(m_done)
    );

    always #5 clk = ~clk;

    task automatic randomize_fields();
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = 7'($urandom);
            op_a[i]   = 1'($urandom);
            din_a[i]  = 8'($urandom);
        end
    endtask

    task automatic drive_req(input logic [NREQ-1:0] mask);
        req = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[7*i +: 7] = addr_a[i];
            req_op[i]          = op_a[i];
            req_din[8*i +: 8]  = din_a[i];
        end
    endtask

    // Reference arbitration: first requesting index after the last winner, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++)
            if (mask[(rr_last + k) % NREQ]) return (rr_last + k) % NREQ;
        return -1;
    endfunction

    // Behavioural master: waits for newd, goes busy, raises done at cycle lat (never if lat<0).
    task automatic serve(input int lat, input logic [7:0] dout, input bit nack);
        o_ok = 0; o_newd_lat = 0; o_resp_cyc = 0; o_extra_newd = 0; o_unstable = 0;
        while (!m_newd && o_newd_lat < 20) begin
            @(negedge clk);
            o_newd_lat++;
        end
        if (!m_newd) return;
        o_addr = m_addr; o_din = m_din; o_op = m_op;
        m_busy = 1'b1;
        for (int c = 1; c <= TIMEOUT + 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                o_ok = 1; o_resp_cyc = c; o_gnt = gnt; o_data = rsp_data;
                o_err = rsp_err; o_tout = rsp_tout;
                m_done = 1'b0; m_ack_err = 1'b0;
                if (lat > 0) m_busy = 1'b0;
                return;
            end
            if (m_newd) o_extra_newd++;
            if ({m_addr, m_din, m_op} !== {o_addr, o_din, o_op}) o_unstable++;
            m_done    = (c == lat);
            m_ack_err = nack && (c == 1);
            m_dout    = (c == lat) ? dout : 8'($urandom);
        end
        m_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, rsp_valid, rsp_data, rsp_err, rsp_tout, m_newd, m_addr, m_op, m_din} !== '0)
            $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h re=%b rt=%b nd=%b a=%h op=%b din=%h want all 0",
                     gnt, rsp_valid, rsp_data, rsp_err, rsp_tout, m_newd, m_addr, m_op, m_din);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        addr_a[0] = 7'h50; op_a[0] = 1'b0; din_a[0] = 8'hA5;
        drive_req(4'b0001);
        serve(5, 8'h77, 0);
        rr_last = 0;
        drive_req(4'b0000);
        checks++;
        if (o_newd_lat !== 1) $display("FAIL write_newd_latency: got %0d want 1", o_newd_lat);
        else passed++;
        checks++;
        if ({o_addr, o_din, o_op} !== {7'h50, 8'hA5, 1'b0})
            $display("FAIL write_master_fields: got a=%h din=%h op=%b want a=50 din=a5 op=0", o_addr, o_din, o_op);
        else passed++;
        checks++;
        if ({o_ok, o_gnt, o_err, o_tout, o_data} !== {1'b1, 4'b0001, 1'b0, 1'b0, 8'h00})
            $display("FAIL write_response: got ok=%b gnt=%b err=%b tout=%b data=%h want ok=1 gnt=0001 err=0 tout=0 data=00",
                     o_ok, o_gnt, o_err, o_tout, o_data);
        else passed++;
        checks++;
        if (o_resp_cyc !== 6) $display("FAIL write_resp_timing: got %0d want 6", o_resp_cyc);
        else passed++;
        @(negedge clk);
        checks++;
        if ({rsp_valid, gnt} !== '0) $display("FAIL write_after_resp: got rv=%b gnt=%b want 0", rsp_valid, gnt);
        else passed++;
    endtask

    task automatic test_single_read();
        addr_a[2] = 7'h3C; op_a[2] = 1'b1; din_a[2] = 8'($urandom);
        drive_req(4'b0100);
        serve(3, 8'h5A, 0);
        rr_last = 2;
        drive_req(4'b0000);
        checks++;
        if ({o_ok, o_gnt, o_addr, o_op, o_data, o_err} !== {1'b1, 4'b0100, 7'h3C, 1'b1, 8'h5A, 1'b0})
            $display("FAIL read_response: got ok=%b gnt=%b a=%h op=%b data=%h err=%b want ok=1 gnt=0100 a=3c op=1 data=5a err=0",
                     o_ok, o_gnt, o_addr, o_op, o_data, o_err);
        else passed++;
        @(negedge clk);
        checks++;
        if ({rsp_valid, gnt, rsp_err, rsp_data} !== {1'b0, 4'b0000, 1'b0, 8'h5A})
            $display("FAIL read_data_hold: got rv=%b gnt=%b err=%b data=%h want 0 0000 0 5a", rsp_valid, gnt, rsp_err, rsp_data);
        else passed++;
    endtask

    task automatic test_round_robin(input int n, input bit rnd);
        logic [NREQ-1:0] mask;
        logic [NREQ+26:0] exp_v, obs_v;
        logic [7:0] dout;
        int w, lat;
        if (!rnd) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            rr_last = NREQ - 1;
        end
        for (int i = 0; i < n; i++) begin
            randomize_fields();
            mask = rnd ? NREQ'($urandom_range(1, (1 << NREQ) - 1)) : '1;
            drive_req(mask);
            w = model_pick(mask);
            rr_last = w;
            lat = $urandom_range(1, 8);
            dout = 8'($urandom);
            serve(lat, dout, 0);
            exp_v = {1'b1, NREQ'(1) << w, addr_a[w], din_a[w], op_a[w], op_a[w] ? dout : 8'h00, 2'b00};
            obs_v = {o_ok, o_gnt, o_addr, o_din, o_op, o_data, o_err, o_tout};
            checks++;
            if (obs_v !== exp_v)
                $display("FAIL rr_txn[%0d] mask=%b: got %h want %h (ok,gnt,addr,din,op,data,err,tout)", i, mask, obs_v, exp_v);
            else passed++;
            checks++;
            if (o_extra_newd !== 0 || o_unstable !== 0)
                $display("FAIL rr_master_if[%0d]: got extra_newd=%0d unstable=%0d want 0 0", i, o_extra_newd, o_unstable);
            else passed++;
            checks++;
            if (o_resp_cyc !== lat + 1) $display("FAIL rr_resp_timing[%0d]: got %0d want %0d", i, o_resp_cyc, lat + 1);
            else passed++;
        end
        drive_req('0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nack();
        int w;
        randomize_fields();
        op_a[1] = 1'b0;
        drive_req(4'b0010);
        rr_last = model_pick(4'b0010);
        serve(4, 8'($urandom), 1);
        checks++;
        if ({o_ok, o_gnt, o_err, o_tout, o_data} !== {1'b1, 4'b0010, 1'b1, 1'b0, 8'h00})
            $display("FAIL nack_response: got ok=%b gnt=%b err=%b tout=%b data=%h want 1 0010 1 0 00",
                     o_ok, o_gnt, o_err, o_tout, o_data);
        else passed++;
        drive_req(4'b0011);
        w = model_pick(4'b0011);
        rr_last = w;
        serve(3, 8'h3E, 0);
        drive_req('0);
        checks++;
        if ({o_ok, o_gnt, o_err, o_tout, o_data} !== {1'b1, NREQ'(1) << w, 1'b0, 1'b0, op_a[w] ? 8'h3E : 8'h00})
            $display("FAIL nack_next_grant: got ok=%b gnt=%b err=%b tout=%b data=%h want gnt=%b err=0 tout=0",
                     o_ok, o_gnt, o_err, o_tout, o_data, NREQ'(1) << w);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int r, extra;
        r = $urandom_range(0, NREQ - 1);
        randomize_fields();
        drive_req(NREQ'(1) << r);
        rr_last = r;
        serve(-1, 8'h00, 0);
        checks++;
        if ({o_ok, o_gnt, o_err, o_tout, o_data} !== {1'b1, NREQ'(1) << r, 1'b1, 1'b1, 8'h00})
            $display("FAIL timeout_response: got ok=%b gnt=%b err=%b tout=%b data=%h want ok=1 gnt=%b err=1 tout=1 data=00",
                     o_ok, o_gnt, o_err, o_tout, o_data, NREQ'(1) << r);
        else passed++;
        checks++;
        if (o_resp_cyc !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d want %0d", o_resp_cyc, TIMEOUT + 1);
        else passed++;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_newd) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL timeout_busy_hold: got %0d newd pulses want 0", extra);
        else passed++;
        m_busy = 1'b0;
        serve(2, 8'hC3, 0);
        drive_req('0);
        checks++;
        if ({o_ok, o_gnt, o_err, o_tout, o_data} !== {1'b1, NREQ'(1) << r, 1'b0, 1'b0, op_a[r] ? 8'hC3 : 8'h00})
            $display("FAIL timeout_recovery: got ok=%b gnt=%b err=%b tout=%b data=%h want gnt=%b err=0 tout=0",
                     o_ok, o_gnt, o_err, o_tout, o_data, NREQ'(1) << r);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n, w;
        randomize_fields();
        op_a[1] = 1'b1;
        drive_req(4'b0010);
        n = 0;
        while (!m_newd && n < 20) begin
            @(negedge clk);
            n++;
        end
        m_busy = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) $display("FAIL areset_pre_gnt: got %b want 0010", gnt);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_data, rsp_err, rsp_tout, m_newd, m_addr, m_op, m_din} !== '0)
            $display("FAIL areset_outputs: got gnt=%b rd=%h a=%h op=%b din=%h want all 0", gnt, rsp_data, m_addr, m_op, m_din);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0;
        rr_last = NREQ - 1;
        drive_req(4'b1110);
        w = model_pick(4'b1110);
        rr_last = w;
        serve(2, 8'h96, 0);
        drive_req('0);
        checks++;
        if ({o_ok, o_gnt, o_addr, o_data} !== {1'b1, NREQ'(1) << w, addr_a[w], op_a[w] ? 8'h96 : 8'h00})
            $display("FAIL areset_first_grant: got ok=%b gnt=%b a=%h data=%h want gnt=%b a=%h", o_ok, o_gnt, o_addr, o_data,
                     NREQ'(1) << w, addr_a[w]);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_addr = '0; req_op = '0; req_din = '0;
        m_dout = '0; m_busy = 1'b0; m_ack_err = 1'b0; m_done = 1'b0;
        checks = 0; passed = 0; rr_last = NREQ - 1;
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin(8, 0);
        test_round_robin(12, 1);
        test_nack();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
